// File: rtl/aes_pkg.sv
// Shared AES constants, FSM/round-type encodings and GF(2^8) multiply helpers
// (reduction polynomial 0x11b) for the decipher datapath.
package aes_pkg;

    localparam int AES_128_NUM_ROUNDS = 10;
    localparam int AES_256_NUM_ROUNDS = 14;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    typedef enum logic [1:0] {
        INIT_ROUND  = 2'd0,
        MAIN_ROUND  = 2'd1,
        FINAL_ROUND = 2'd2
    } round_type_e;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_INIT  = 2'd1,
        CTRL_MAIN  = 2'd2,
        CTRL_FINAL = 2'd3
    } dec_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// InvMixColumns on one 32-bit column; byte [31:24] is row 0.
module aes_inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3);
    assign col_out[23:16] = gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3);
    assign col_out[15:8]  = gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3);
    assign col_out[7:0]   = gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3);

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte, purely combinational lookup.
module aes_inv_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sbox_out = INV_SBOX[sbox_in];

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index
// from an external key memory in the same cycle.
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         valid,
    output logic [1:0]   dbg_state
);

    dec_state_e   ctrl_q, ctrl_d;
    logic [127:0] aes_state_q, aes_state_d;
    logic [127:0] new_block_q, new_block_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic         keylen_q, keylen_d;
    logic         valid_q, valid_d;
    round_type_e  round_type;
    logic [127:0] shifted, subbed, added, mixed, round_result;

    // Byte i of the state sits at [127-8i -: 8]; i = row + 4*col.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    assign shifted = inv_shift_rows(aes_state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .sbox_in  (shifted[127 - 8 * i -: 8]),
            .sbox_out (subbed[127 - 8 * i -: 8])
        );
    end

    assign added = subbed ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_inv_mixcolumns u_inv_mix (
            .col_in  (added[127 - 32 * c -: 32]),
            .col_out (mixed[127 - 32 * c -: 32])
        );
    end

    always_comb begin
        round_result = aes_state_q ^ round_key;
        case (round_type)
            MAIN_ROUND:  round_result = mixed;
            FINAL_ROUND: round_result = added;
            default:     round_result = aes_state_q ^ round_key;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= CTRL_IDLE;
            aes_state_q <= '0;
            new_block_q <= '0;
            round_ctr_q <= '0;
            keylen_q    <= KEYLEN_128;
            valid_q     <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            aes_state_q <= aes_state_d;
            new_block_q <= new_block_d;
            round_ctr_q <= round_ctr_d;
            keylen_q    <= keylen_d;
            valid_q     <= valid_d;
        end
    end

    // MAIN hands over to FINAL on the edge where the counter reaches 0.
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            CTRL_IDLE:  if (next) ctrl_d = CTRL_INIT;
            CTRL_INIT:  ctrl_d = CTRL_MAIN;
            CTRL_MAIN:  if (round_ctr_q == 4'd1) ctrl_d = CTRL_FINAL;
            CTRL_FINAL: ctrl_d = CTRL_IDLE;
            default:    ctrl_d = CTRL_IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        round_type = MAIN_ROUND;
        case (ctrl_q)
            CTRL_IDLE:  ready      = 1'b1;
            CTRL_INIT:  round_type = INIT_ROUND;
            CTRL_FINAL: round_type = FINAL_ROUND;
            default:    ;
        endcase
    end

    always_comb begin
        aes_state_d = aes_state_q;
        new_block_d = new_block_q;
        round_ctr_d = round_ctr_q;
        keylen_d    = keylen_q;
        valid_d     = valid_q;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (next) begin
                    aes_state_d = block;
                    keylen_d    = keylen;
                    valid_d     = 1'b0;
                    round_ctr_d = (keylen == KEYLEN_256) ? 4'(AES_256_NUM_ROUNDS)
                                                         : 4'(AES_128_NUM_ROUNDS);
                end
            end
            CTRL_INIT, CTRL_MAIN: begin
                aes_state_d = round_result;
                round_ctr_d = round_ctr_q - 4'd1;
            end
            CTRL_FINAL: begin
                aes_state_d = round_result;
                new_block_d = round_result;
                valid_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign round     = round_ctr_q;
    assign new_block = new_block_q;
    assign valid     = valid_q;
    assign dbg_state = ctrl_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: key memory and a forward AES cipher model built
// from first principles; ciphertexts come from that model, plaintexts are expected back.
module tb_aes_decipher_block;

    localparam logic [255:0] C1_KEY = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
    logic         valid;
    logic [1:0]   dbg_state;

    logic [7:0]   sbox [256];
    logic [127:0] rk_mem [16];
    logic [127:0] last_result;
    int           n_checks;
    int           n_errors;

    always #5 clk = ~clk;

    assign round_key = rk_mem[round];

    aes_decipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready),
        .valid     (valid),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_mem[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else rk_mem[r] = '0;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ rk_mem[0];
        for (int rr = 1; rr <= nr; rr++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[v[127 - 8 * i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (rr != nr) begin
                    s[4 * c]     = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4 * c + 1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4 * c + 2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4 * c + 3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * c + r];
                end
            end
            for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[i];
            v = v ^ rk_mem[rr];
        end
        return v;
    endfunction

    // Starts an operation at a negedge and walks it cycle by cycle to completion.
    task automatic run_op(input logic [127:0] ct, input logic kl, input logic [127:0] exp_pt,
                          input int poke_k, input bit keep_next, input string tag);
        int nr;
        nr = kl ? 14 : 10;
        block  = ct;
        keylen = kl;
        next   = 1'b1;
        @(negedge clk);
        if (!keep_next) next = 1'b0;
        chk({tag, "_valid_clear"}, {127'h0, valid}, 128'h0);
        chk({tag, "_new_block_retained"}, new_block, last_result);
        for (int k = 0; k <= nr; k++) begin
            chk({tag, "_round_seq"}, {124'h0, round}, 128'(nr - k));
            chk({tag, "_busy"}, {127'h0, ready}, 128'h0);
            if (k == poke_k) begin
                next   = 1'b1;
                keylen = 1'b1;
                block  = {$urandom, $urandom, $urandom, $urandom};
            end else if (!keep_next) begin
                next = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_ready_done"}, {127'h0, ready}, 128'h1);
        chk({tag, "_valid_done"}, {127'h0, valid}, 128'h1);
        chk({tag, "_plaintext"}, new_block, exp_pt);
        last_result = exp_pt;
    endtask

    initial begin
        logic [255:0] rkey;
        logic [127:0] pt;
        logic [127:0] ct;
        logic         kl;

        n_checks    = 0;
        n_errors    = 0;
        last_result = '0;
        reset_n     = 1'b0;
        next        = 1'b0;
        keylen      = 1'b0;
        block       = '0;
        build_sbox();
        expand_key(C1_KEY, 4);

        repeat (2) @(negedge clk);
        chk("reset_ready", {127'h0, ready}, 128'h1);
        chk("reset_valid", {127'h0, valid}, 128'h0);
        chk("reset_new_block", new_block, 128'h0);
        chk("reset_round", {124'h0, round}, 128'h0);
        chk("reset_fsm_idle", {126'h0, dbg_state}, 128'(aes_pkg::CTRL_IDLE));
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            block = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("idle_ready", {127'h0, ready}, 128'h1);
            chk("idle_valid", {127'h0, valid}, 128'h0);
            chk("idle_round", {124'h0, round}, 128'h0);
            chk("idle_new_block", new_block, 128'h0);
        end

        run_op(C1_CT, 1'b0, FIPS_PT, -1, 1'b0, "c1");

        expand_key(C3_KEY, 8);
        run_op(C3_CT, 1'b1, FIPS_PT, -1, 1'b0, "c3");

        expand_key(C1_KEY, 4);
        run_op(C1_CT, 1'b0, FIPS_PT, 4, 1'b0, "busy_ignore");

        // Reset partway through an AES-256 operation, then restart with AES-128.
        expand_key(C3_KEY, 8);
        block  = C3_CT;
        keylen = 1'b1;
        next   = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (5) @(negedge clk);
        chk("midop_in_flight", {127'h0, ready}, 128'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("midop_reset_ready", {127'h0, ready}, 128'h1);
        chk("midop_reset_valid", {127'h0, valid}, 128'h0);
        chk("midop_reset_new_block", new_block, 128'h0);
        chk("midop_reset_round", {124'h0, round}, 128'h0);
        @(negedge clk);
        reset_n     = 1'b1;
        last_result = '0;
        expand_key(C1_KEY, 4);
        run_op(C1_CT, 1'b0, FIPS_PT, -1, 1'b0, "after_reset");

        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt, 10);
        run_op(C1_CT, 1'b0, FIPS_PT, -1, 1'b1, "b2b_first");
        run_op(ct, 1'b0, pt, -1, 1'b0, "b2b_second");

        for (int n = 0; n < 6; n++) begin
            kl   = 1'($urandom_range(0, 1));
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand_key(rkey, kl ? 8 : 4);
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt, kl ? 14 : 10);
            run_op(ct, kl, pt, -1, 1'b0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
